// File: rtl/inv_key_expansion_128.sv
// AES-128 inverse key schedule: takes the round-NR key and steps one working
// register backwards to emit round keys NR..0 over a valid/ready handshake.
module inv_key_expansion_128 #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    int unsigned idx;
    idx = 32'd2047 - 32'd8 * {24'd0, x};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [0:0]   state;
  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  na, nb, nc, nd;
  logic [127:0] prev_key;

  // Undo the forward recurrence from the last word back; the new a needs the
  // already-recovered d, which is why nd is computed first.
  always_comb begin
    wa = rk_data[127:96];
    wb = rk_data[95:64];
    wc = rk_data[63:32];
    wd = rk_data[31:0];
    nd = wd ^ wc;
    nc = wc ^ wb;
    nb = wb ^ wa;
    na = wa ^ sub_word({nd[23:0], nd[31:24]}) ^ {rcon(rk_round), 24'h0};
    prev_key = {na, nb, nc, nd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk_data  <= key_in;
            rk_round <= 4'(NR);
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (abort) begin
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (rk_valid && rk_ready) begin
            if (rk_round != 4'd0) begin
              rk_data  <= prev_key;
              rk_round <= rk_round - 4'd1;
            end else begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
